// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default
// widths, the $0 register constant, arbiter states and the buffered request.
package wb_write_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Register $0 is hard-wired; writes to it are never issued.
    localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;

    // IDLE: buffer empty, PEND: buffer non-empty with pipe priority,
    // DRAIN: pipeline frozen while the buffer is emptied.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    // Default-width write request (destination register plus data).
    typedef struct packed {
        logic [REG_W_DEF-1:0]  dest;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_write_arbiter_lu_fifo.sv
// Small circular FIFO holding long-latency results. Each slot carries a
// valid bit so a younger pipe write to the same register can cancel the
// buffered result in place; cancelled slots still occupy their position and
// are popped silently by the arbiter.
module wb_lu_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  REG_W = REG_W_DEF,
    parameter type req_t = wb_req_t
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push_i,
    input  req_t                   push_req_i,
    input  logic                   pop_i,
    input  logic                   kill_en_i,
    input  logic [REG_W-1:0]       kill_dest_i,
    output req_t                   head_req_o,
    output logic                   head_valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    req_t             mem_q [DEPTH];
    logic [DEPTH-1:0] valid_vec;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Payload storage: written on push only, contents are qualified by valid bits.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic slot_valid_q;

            // Per-slot valid: set by push, cleared by pop or a matching kill.
            // A push only ever lands in an unoccupied slot, so it takes priority.
            always_ff @(posedge clk) begin
                if (srst) begin
                    slot_valid_q <= 1'b0;
                end else if (push_i && (wr_ptr_q == PTR_W'(gi))) begin
                    slot_valid_q <= 1'b1;
                end else if (pop_i && (rd_ptr_q == PTR_W'(gi))) begin
                    slot_valid_q <= 1'b0;
                end else if (kill_en_i && (mem_q[gi].dest == kill_dest_i)) begin
                    slot_valid_q <= 1'b0;
                end
            end

            assign valid_vec[gi] = slot_valid_q;
        end
    endgenerate

    assign head_req_o   = mem_q[rd_ptr_q];
    assign head_valid_o = valid_vec[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Owner of the single register-file write port. In-order write-back has
// priority; long-latency results are buffered and slipped into idle slots,
// and a result that waits too long freezes the pipeline until drained.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pipe_reg_write,
    input  logic [REG_W-1:0]           pipe_dest,
    input  logic [DATA_W-1:0]          pipe_data,
    input  logic                       lu_valid,
    input  logic [REG_W-1:0]           lu_dest,
    input  logic [DATA_W-1:0]          lu_data,
    output logic                       lu_ready,
    output logic                       rf_write_en,
    output logic [REG_W-1:0]           rf_write_addr,
    output logic [DATA_W-1:0]          rf_write_data,
    output logic                       pipe_stall,
    output logic [$clog2(BUF_DEPTH):0] buf_count
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } req_t;

    arb_state_t        state_q, state_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              rf_en_q;
    logic [REG_W-1:0]  rf_addr_q;
    logic [DATA_W-1:0] rf_data_q;
    logic              stall_q;

    logic              eff_pipe;
    logic              lu_push;
    logic              fifo_pop;
    logic              kill_en;
    logic              issue_en;
    logic [REG_W-1:0]  issue_addr;
    logic [DATA_W-1:0] issue_data;
    logic [CNT_W-1:0]  cnt_next;
    req_t              push_req;
    req_t              head_req;
    logic              head_valid;

    assign eff_pipe      = pipe_reg_write && (pipe_dest != REG_W'(REG_ZERO));
    assign lu_ready      = (buf_count < CNT_W'(BUF_DEPTH)) && !reset;
    // A result for $0 completes the handshake but is simply dropped.
    assign lu_push       = lu_valid && lu_ready && (lu_dest != REG_W'(REG_ZERO));
    assign push_req.dest = lu_dest;
    assign push_req.data = lu_data;

    wb_lu_fifo #(
        .DEPTH (BUF_DEPTH),
        .REG_W (REG_W),
        .req_t (req_t)
    ) u_fifo (
        .clk          (clk),
        .srst         (reset),
        .push_i       (lu_push),
        .push_req_i   (push_req),
        .pop_i        (fifo_pop),
        .kill_en_i    (kill_en),
        .kill_dest_i  (pipe_dest),
        .head_req_o   (head_req),
        .head_valid_o (head_valid),
        .count_o      (buf_count)
    );

    // Slot selection, starvation tracking and next-state decision.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        fifo_pop   = 1'b0;
        kill_en    = 1'b0;
        issue_en   = 1'b0;
        issue_addr = rf_addr_q;
        issue_data = rf_data_q;

        case (state_q)
            ST_IDLE: begin
                starve_d = '0;
                if (eff_pipe) begin
                    issue_en   = 1'b1;
                    issue_addr = pipe_dest;
                    issue_data = pipe_data;
                end
            end
            ST_PEND: begin
                if (eff_pipe) begin
                    // Pipe write is younger than anything buffered for the same register.
                    issue_en   = 1'b1;
                    issue_addr = pipe_dest;
                    issue_data = pipe_data;
                    kill_en    = 1'b1;
                    if (starve_q != STV_W'(STARVE_LIMIT)) begin
                        starve_d = starve_q + STV_W'(1);
                    end
                end else begin
                    fifo_pop   = 1'b1;
                    issue_en   = head_valid;
                    issue_addr = head_req.dest;
                    issue_data = head_req.data;
                    starve_d   = '0;
                end
            end
            ST_DRAIN: begin
                // Pipe inputs are ignored; the WB stage is frozen and holds them.
                fifo_pop   = 1'b1;
                issue_en   = head_valid;
                issue_addr = head_req.dest;
                issue_data = head_req.data;
                starve_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cnt_next = buf_count + CNT_W'(lu_push) - CNT_W'(fifo_pop);

        case (state_q)
            ST_IDLE: begin
                if (lu_push) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (cnt_next == '0) begin
                    state_d = ST_IDLE;
                end else if (starve_d == STV_W'(STARVE_LIMIT)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_next == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, starvation counter and registered write-port / stall outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            starve_q  <= '0;
            rf_en_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            stall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rf_en_q  <= issue_en;
            if (issue_en) begin
                rf_addr_q <= issue_addr;
                rf_data_q <= issue_data;
            end
            stall_q <= (state_d == ST_DRAIN);
        end
    end

    assign rf_write_en   = rf_en_q;
    assign rf_write_addr = rf_addr_q;
    assign rf_write_data = rf_data_q;
    assign pipe_stall    = stall_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_wb_write_arbiter;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int DEPTH  = 2;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pipe_reg_write = 1'b0;
    logic [REG_W-1:0]  pipe_dest = '0;
    logic [DATA_W-1:0] pipe_data = '0;
    logic              lu_valid = 1'b0;
    logic [REG_W-1:0]  lu_dest = '0;
    logic [DATA_W-1:0] lu_data = '0;
    logic              lu_ready;
    logic              rf_write_en;
    logic [REG_W-1:0]  rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              pipe_stall;
    logic [1:0]        buf_count;

    wb_write_arbiter #(
        .DATA_W       (DATA_W),
        .REG_W        (REG_W),
        .BUF_DEPTH    (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_reg_write (pipe_reg_write),
        .pipe_dest      (pipe_dest),
        .pipe_data      (pipe_data),
        .lu_valid       (lu_valid),
        .lu_dest        (lu_dest),
        .lu_data        (lu_data),
        .lu_ready       (lu_ready),
        .rf_write_en    (rf_write_en),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .pipe_stall     (pipe_stall),
        .buf_count      (buf_count)
    );

    always #5 clk = ~clk;

    // Reference model: buffered results in program order, a drain flag and
    // a count of cycles the oldest result has been passed over.
    typedef struct {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
        bit                live;
    } ent_t;

    ent_t              q[$];
    bit                draining = 1'b0;
    int                starve = 0;
    bit                exp_en = 1'b0;
    logic [REG_W-1:0]  exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs now applied.
    task automatic model_step();
        bit   eff;
        bit   push;
        bit   do_pop;
        ent_t e;
        ent_t n;
        exp_en = 1'b0;
        if (reset) begin
            q.delete();
            draining = 1'b0;
            starve   = 0;
            exp_addr = '0;
            exp_data = '0;
            return;
        end
        push   = lu_valid && (q.size() < DEPTH) && (lu_dest != 0);
        eff    = pipe_reg_write && (pipe_dest != 0);
        do_pop = draining || (q.size() > 0 && !eff);
        if (!do_pop && eff) begin
            exp_en   = 1'b1;
            exp_addr = pipe_dest;
            exp_data = pipe_data;
            foreach (q[i]) begin
                if (q[i].dest == pipe_dest) q[i].live = 1'b0;
            end
            if (q.size() > 0 && starve < LIMIT) starve++;
        end
        if (do_pop) begin
            e = q.pop_front();
            starve = 0;
            if (e.live) begin
                exp_en   = 1'b1;
                exp_addr = e.dest;
                exp_data = e.data;
            end
        end
        if (push) begin
            n.dest = lu_dest;
            n.data = lu_data;
            n.live = 1'b1;
            q.push_back(n);
        end
        if (q.size() == 0) begin
            draining = 1'b0;
            starve   = 0;
        end else if (!draining && starve == LIMIT) begin
            draining = 1'b1;
        end
    endtask

    // Apply one cycle of stimulus; a stalled WB stage keeps its outputs.
    task automatic cycle(input bit rst, input bit pw, input logic [REG_W-1:0] pd,
                         input logic [DATA_W-1:0] pdat, input bit lv,
                         input logic [REG_W-1:0] ld, input logic [DATA_W-1:0] ldat);
        @(negedge clk);
        reset = rst;
        if (!pipe_stall || rst) begin
            pipe_reg_write = pw;
            pipe_dest      = pd;
            pipe_data      = pdat;
        end
        lu_valid = lv;
        lu_dest  = ld;
        lu_data  = ldat;
        #1;
        check_val("lu_ready", {63'd0, lu_ready}, {63'd0, (!rst && q.size() < DEPTH)});
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_val("rf_write_en", {63'd0, rf_write_en}, {63'd0, exp_en});
        if (exp_en || rst) begin
            check_val("rf_write_addr", 64'(rf_write_addr), 64'(exp_addr));
            check_val("rf_write_data", 64'(rf_write_data), 64'(exp_data));
        end
        check_val("pipe_stall", {63'd0, pipe_stall}, {63'd0, draining});
        check_val("buf_count", 64'(buf_count), 64'(q.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        int budget;
        // Reset
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

        // Pipe only, including a $0 write that must be suppressed
        cycle(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0);
        idle(1);

        // Long-latency result into an idle port
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd8, 32'hAA);
        idle(3);

        // Full buffer under continuous pipe writes, then starvation drain
        cycle(1'b0, 1'b1, 5'd1, 32'h100, 1'b1, 5'd9,  32'hB0);
        cycle(1'b0, 1'b1, 5'd2, 32'h101, 1'b1, 5'd10, 32'hB1);
        cycle(1'b0, 1'b1, 5'd4, 32'h102, 1'b1, 5'd11, 32'hB2);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 5'(12 + i), 32'(32'h200 + i), 1'b0, '0, '0);
        idle(3);

        // WAW kill: buffered $3 overtaken by a younger pipe write to $3
        cycle(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h11);
        cycle(1'b0, 1'b1, 5'd3, 32'h22, 1'b0, '0, '0);
        idle(3);

        // Reset in the middle of a drain
        cycle(1'b0, 1'b1, 5'd6, 32'h60, 1'b1, 5'd20, 32'hC0);
        cycle(1'b0, 1'b1, 5'd7, 32'h61, 1'b1, 5'd21, 32'hC1);
        budget = 0;
        while (!pipe_stall && budget < 20) begin
            cycle(1'b0, 1'b1, 5'd7, 32'h62, 1'b0, '0, '0);
            budget++;
        end
        check_val("drain_reached", {63'd0, pipe_stall}, 64'd1);
        cycle(1'b1, 1'b1, 5'd7, 32'h62, 1'b0, '0, '0);
        idle(3);

        // Randomized traffic with rising pipe pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 400; i++) begin
                bit rst;
                bit pw;
                bit lv;
                rst = ($urandom_range(0, 199) == 0);
                pw  = ($urandom_range(0, 99) < (30 + ph * 23));
                lv  = ($urandom_range(0, 99) < 40);
                cycle(rst, pw, 5'($urandom_range(0, 7)), $urandom,
                      lv, 5'($urandom_range(0, 7)), $urandom);
            end
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between the in-order pipeline write-back (WB stage outputs: reg write, destination, wb data) and a long-latency unit (mult/div) that completes out of band.
- Long-latency results are buffered in a small FIFO and drained into idle write-port slots.
- If a buffered result starves, the block stalls the pipeline to force a drain.

Parameters:
- DATA_W, 32, register data width
- REG_W, 5, register address width
- BUF_DEPTH, 2, long-latency FIFO entries (power of two, >=2)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before a forced drain

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pipe_reg_write  in  1  WB stage write enable
- pipe_dest  in  REG_W  WB stage destination register
- pipe_data  in  DATA_W  WB stage write data
- lu_valid  in  1  long-latency result valid
- lu_dest  in  REG_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result
- lu_ready  out  1  FIFO can accept; transfer occurs when lu_valid && lu_ready
- rf_write_en  out  1  registered register-file write enable
- rf_write_addr  out  REG_W  registered write address
- rf_write_data  out  DATA_W  registered write data
- pipe_stall  out  1  registered; freezes the pipeline, with the WB stage holding its outputs
- buf_count  out  clog2(BUF_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (synchronous, evaluated at the clock edge):
  - FIFO flushed; starvation counter = 0; state = IDLE.
  - rf_write_en = 0, rf_write_addr = 0, rf_write_data = 0, pipe_stall = 0, buf_count = 0.
  - Reset mid-operation discards buffered results without writing them.
- Effective pipe write: pipe_reg_write && pipe_dest != 0. Writes to $0 are never issued.
- lu_ready = (buf_count < BUF_DEPTH) && !reset. It is combinational from registered count only.
- Enqueue:
  - lu_valid && lu_ready pushes {lu_dest, lu_data}.
  - An lu_dest of 0 is accepted but not enqueued.
- Port latency: the selected write appears on rf_write_* exactly 1 cycle after selection.
- State machine:
  - IDLE (FIFO empty):
    - Effective pipe write is issued.
    - Any enqueue -> PEND.
  - PEND (FIFO non-empty, pipe has priority):
    - If an effective pipe write is present, issue it; the FIFO head waits and the starve counter increments.
    - Otherwise, pop the head, issue it, and clear the starve counter.
    - When the counter reaches STARVE_LIMIT -> DRAIN.
    - FIFO becomes empty with no enqueue in the same cycle -> IDLE.
  - DRAIN:
    - pipe_stall = 1 (registered, so it is visible starting the cycle DRAIN is entered).
    - Pop and issue the head each cycle; pipe inputs are ignored.
    - The pipe write is deferred, not lost, because the WB stage holds its outputs.
    - Exits to IDLE when the FIFO is empty; pipe_stall drops the same edge.
    - Enqueues during DRAIN are allowed and extend the drain.
- Simultaneous push and pop in one cycle: count is unchanged; pointers wrap modulo BUF_DEPTH.
- WAW kill:
  - An issued pipe write whose dest equals the dest of any valid FIFO entry invalidates that entry, because the pipe write is younger in program order.
  - An invalidated entry is popped without asserting rf_write_en, which costs one slot.
  - A same-cycle enqueue with a dest matching an issued pipe write is enqueued normally, because the long-latency result is the younger one.
- Starvation counter saturates at STARVE_LIMIT and is cleared on every successful pop.

Decomposition:
- Shared package:
  - DATA_W/REG_W defaults
  - REG_ZERO constant
  - arbiter state enum {IDLE, PEND, DRAIN}
  - wb_req_t struct {dest, data}
- One natural sub-module: wb_lu_fifo. It is a parameterized circular FIFO with a per-entry valid bit and a dest-match kill port; the arbiter FSM and output registers stay in the top level.

Test Plan:
- Pipe only: pipe write $5 = 0x1234 at cycle 0 -> rf_write_en = 1, addr 5, data 0x1234 at cycle 1; pipe_dest = 0 -> no write.
- LU into idle port: lu_valid dest 8 = 0xAA with no pipe write -> enqueued; written addr 8 = 0xAA two cycles later; buf_count returns to 0.
- Full FIFO: pipe writes every cycle; three LU results offered -> two accepted, lu_ready = 0 thereafter; no result lost or duplicated.
- Starvation: pipe writes continuous; FIFO head waits 4 cycles -> pipe_stall = 1, both entries written in order, pipe_stall = 0, the held pipe write is issued next.
- WAW kill: FIFO holds dest 3 = 0x11; pipe writes $3 = 0x22 -> only 0x22 reaches the RF, and the entry pops silently.
- Reset mid-DRAIN: reset asserted with 2 entries -> next cycle buf_count = 0, pipe_stall = 0, rf_write_en = 0, no further writes.
